// File: rtl/sfr_ctrl_pkg.sv
// Shared types for the SFR bank arbiter: FSM state encoding and requester count.
package sfr_ctrl_pkg;

  localparam int NUM_MST = 2;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    ACCESS,
    RESP
  } sfr_ctrl_state_e;

endpackage

// File: rtl/sfr_rr_arbiter.sv
// Two-way round-robin winner select; winner is combinational, last grant is registered.
// On a tie the requester that did not win last time wins; a lone requester always wins.
module sfr_rr_arbiter
  import sfr_ctrl_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_MST-1:0] req_i,
  input  logic               upd_i,
  input  logic               upd_idx_i,
  output logic               any_o,
  output logic               win_o
);

  logic last_gnt_q;

  // Reset favours requester 0 on the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_gnt_q <= 1'b1;
    end else if (upd_i) begin
      last_gnt_q <= upd_idx_i;
    end
  end

  assign any_o = |req_i;
  assign win_o = (&req_i) ? ~last_gnt_q : req_i[1];

endmodule

// File: rtl/sfr_bus_arbiter.sv
// Shares one SFR bank between core (0) and debug (1): grant, one-cycle register access, done pulse.
// Request-to-done is 3 cycles; requesters hold req until granted, fields are taken in the grant cycle.
module sfr_bus_arbiter
  import sfr_ctrl_pkg::*;
#(
  parameter int NUM_SFR    = 8,
  parameter int SFR_WIDTH  = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                           sys_clk,
  input  logic                           sys_rst,
  input  logic [NUM_MST-1:0]             mst_req,
  input  logic [NUM_MST-1:0]             mst_we,
  input  logic [NUM_MST*ADDR_WIDTH-1:0]  mst_addr,
  input  logic [NUM_MST*SFR_WIDTH-1:0]   mst_wdata,
  output logic [NUM_MST-1:0]             mst_gnt,
  output logic [NUM_MST-1:0]             mst_done,
  output logic [SFR_WIDTH-1:0]           mst_rdata,
  output logic                           mst_err,
  output logic [NUM_SFR-1:0]             sfr_clk_en,
  output logic [NUM_SFR-1:0]             sfr_wen,
  output logic [SFR_WIDTH-1:0]           sfr_sw_value,
  input  logic [NUM_SFR*SFR_WIDTH-1:0]   sfr_rd_bus
);

  localparam int IDX_W = (NUM_SFR > 1) ? $clog2(NUM_SFR) : 1;
  localparam logic [ADDR_WIDTH:0] NUM_SFR_A = (ADDR_WIDTH+1)'(NUM_SFR);

  function automatic logic hit_f(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} < NUM_SFR_A);
  endfunction

  sfr_ctrl_state_e          state_q, state_d;
  logic                     owner_q;
  logic                     we_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [SFR_WIDTH-1:0]     wdata_q;
  logic [NUM_MST-1:0]       gnt_q, done_q;
  logic [NUM_SFR-1:0]       clk_en_q, wen_q;
  logic [SFR_WIDTH-1:0]     rdata_q;
  logic                     err_q;

  logic [NUM_MST-1:0]       elig;
  logic                     any_req, win;
  logic                     cur_we;
  logic [ADDR_WIDTH-1:0]    cur_addr;
  logic [SFR_WIDTH-1:0]     cur_wdata;
  logic [NUM_SFR-1:0]       cur_oh;
  logic [SFR_WIDTH-1:0]     rd_sel;

  // The requester completing in RESP is treated as stale so it cannot be re-granted back to back.
  always_comb begin
    elig = mst_req;
    if (state_q == RESP) elig[owner_q] = 1'b0;
  end

  sfr_rr_arbiter u_arb (
    .clk_i     (sys_clk),
    .rst_i     (sys_rst),
    .req_i     (elig),
    .upd_i     (state_q == GRANT),
    .upd_idx_i (owner_q),
    .any_o     (any_req),
    .win_o     (win)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = GRANT;
      GRANT:   state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = any_req ? GRANT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cur_we    = mst_we[owner_q];
  assign cur_addr  = owner_q ? mst_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : mst_addr[ADDR_WIDTH-1:0];
  assign cur_wdata = owner_q ? mst_wdata[2*SFR_WIDTH-1:SFR_WIDTH] : mst_wdata[SFR_WIDTH-1:0];
  assign cur_oh    = hit_f(cur_addr) ? (NUM_SFR'(1) << cur_addr[IDX_W-1:0]) : '0;

  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < NUM_SFR; k++) begin
      if (addr_q[IDX_W-1:0] == IDX_W'(k)) rd_sel = sfr_rd_bus[k*SFR_WIDTH +: SFR_WIDTH];
    end
  end

  // Enables are decoded during GRANT so the SFR sees registered, glitch-free strobes in ACCESS.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      clk_en_q <= '0;
      wen_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= '0;
      done_q   <= '0;
      clk_en_q <= '0;
      wen_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      if (state_d == GRANT) begin
        owner_q    <= win;
        gnt_q[win] <= 1'b1;
      end
      if (state_q == GRANT) begin
        we_q     <= cur_we;
        addr_q   <= cur_addr;
        wdata_q  <= cur_wdata;
        clk_en_q <= cur_oh;
        wen_q    <= cur_we ? cur_oh : '0;
      end
      if (state_q == ACCESS) begin
        done_q[owner_q] <= 1'b1;
        err_q           <= ~hit_f(addr_q);
        rdata_q         <= (hit_f(addr_q) && !we_q) ? rd_sel : '0;
      end
    end
  end

  assign mst_gnt      = gnt_q;
  assign mst_done     = done_q;
  assign mst_rdata    = rdata_q;
  assign mst_err      = err_q;
  assign sfr_clk_en   = clk_en_q;
  assign sfr_wen      = wen_q;
  assign sfr_sw_value = wdata_q;

endmodule
